pwr_seq_ctrl: RTL and testbench

- Parametrised power-sequencing controller for `NUM_DOM` switchable power domains.
- Per domain, it drives the isolation, retention save/restore, power-switch enable and domain-reset controls that the testbench currently toggles by hand.
- Each domain sequences independently, with programmable-by-parameter setup/hold/settle intervals and a power-good timeout.
- Sits in the always-on domain next to the UPF-managed top, feeding `iso_enable`/`save`/`restore` per domain.

---
 rtl/pwr_seq_pkg.sv | 32 +++
 rtl/pwr_seq_if.sv | 9 +
 rtl/pwr_seq_ctrl_dom_fsm.sv | 60 ++++++
 rtl/pwr_seq_ctrl.sv | 32 +++
 tb/tb_pwr_seq_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/pwr_seq_pkg.sv
// pwr_seq_pkg: shared state encoding, per-state output decode and counter sizing
package pwr_seq_pkg;
  typedef enum logic [3:0] {ON, ISO, SAVE, PWR_DN, OFF, PWR_UP, RST_WAIT, RESTORE, DEISO} pwr_state_e;
  typedef struct packed {
    logic pwr_en;
    logic iso_en;
    logic dom_rst_n;
    logic save;
    logic restore;
    logic asleep;
    logic busy;
  } pwr_out_t;
  function automatic int cnt_width(int a, int b, int c, int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction
  function automatic pwr_out_t state_out(pwr_state_e s);
    pwr_out_t o;
    o.pwr_en    = !(s inside {PWR_DN, OFF});
    o.iso_en    = s != ON;
    o.dom_rst_n = !(s inside {OFF, PWR_UP, RST_WAIT});
    o.save      = s == SAVE;
    o.restore   = s == RESTORE;
    o.asleep    = s == OFF;
    o.busy      = !(s inside {ON, OFF});
    return o;
  endfunction
endpackage

// File: rtl/pwr_seq_if.sv
// pwr_seq_if: per-domain request, power-good and sequencing control bundle
interface pwr_seq_if #(parameter int NUM_DOM = 2);
  logic [NUM_DOM-1:0] sleep_req, pwr_good, iso_en, save, restore, pwr_en, dom_rst_n, asleep, busy, err;
  logic err_clr;
  modport master (input sleep_req, pwr_good, err_clr,
                  output iso_en, save, restore, pwr_en, dom_rst_n, asleep, busy, err);
  modport slave (output sleep_req, pwr_good, err_clr,
                 input iso_en, save, restore, pwr_en, dom_rst_n, asleep, busy, err);
endinterface

// File: rtl/pwr_seq_ctrl_dom_fsm.sv
// pwr_dom_fsm: one domain's power sequencer with interval counter and registered outputs
module pwr_dom_fsm import pwr_seq_pkg::*; #(
  parameter int ISO_SETUP  = 1,
  parameter int ISO_HOLD   = 1,
  parameter int RST_SETTLE = 2,
  parameter int PG_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sleep_req,
  input  logic pwr_good,
  input  logic err_clr,
  output logic iso_en,
  output logic save,
  output logic restore,
  output logic pwr_en,
  output logic dom_rst_n,
  output logic asleep,
  output logic busy,
  output logic err
);
  localparam int W = cnt_width(ISO_SETUP, ISO_HOLD, RST_SETTLE, PG_TIMEOUT);
  pwr_state_e state, state_nx;
  logic [W-1:0] cnt, cnt_nx;
  logic err_nx;
  pwr_out_t outs;
  always_comb begin
    state_nx = state;
    case (state)
      ON:       state_nx = sleep_req ? ISO : ON;
      ISO:      state_nx = cnt == W'(ISO_SETUP - 1) ? SAVE : ISO;
      SAVE:     state_nx = PWR_DN;
      PWR_DN:   state_nx = pwr_good ? PWR_DN : OFF;
      OFF:      state_nx = sleep_req ? OFF : PWR_UP;
      PWR_UP:   state_nx = pwr_good ? RST_WAIT : PWR_UP;
      RST_WAIT: state_nx = cnt == W'(RST_SETTLE - 1) ? RESTORE : RST_WAIT;
      RESTORE:  state_nx = DEISO;
      DEISO:    state_nx = cnt == W'(ISO_HOLD - 1) ? ON : DEISO;
      default:  state_nx = ON;
    endcase
    cnt_nx = state_nx != state ? '0 : (&cnt ? cnt : cnt + W'(1));
    // a fresh timeout outranks a simultaneous clear
    err_nx = (err & ~err_clr) |
             ((state inside {PWR_DN, PWR_UP}) && state_nx == state && cnt == W'(PG_TIMEOUT - 1));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ON;
      cnt   <= '0;
      err   <= 1'b0;
      outs  <= state_out(ON);
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      err   <= err_nx;
      outs  <= state_out(state_nx);
    end
  end
  assign {pwr_en, iso_en, dom_rst_n, save, restore, asleep, busy} = outs;
endmodule

// File: rtl/pwr_seq_ctrl.sv
// pwr_seq_ctrl: NUM_DOM independent power-domain sequencers sharing one error clear
module pwr_seq_ctrl import pwr_seq_pkg::*; #(
  parameter int NUM_DOM    = 2,
  parameter int ISO_SETUP  = 1,
  parameter int ISO_HOLD   = 1,
  parameter int RST_SETTLE = 2,
  parameter int PG_TIMEOUT = 16
) (
  input logic clk,
  input logic rst,
  pwr_seq_if.master bus
);
  for (genvar i = 0; i < NUM_DOM; i++) begin : g_dom
    pwr_dom_fsm #(
      .ISO_SETUP(ISO_SETUP), .ISO_HOLD(ISO_HOLD), .RST_SETTLE(RST_SETTLE), .PG_TIMEOUT(PG_TIMEOUT)
    ) u_dom (
      .clk(clk),
      .rst(rst),
      .sleep_req(bus.sleep_req[i]),
      .pwr_good(bus.pwr_good[i]),
      .err_clr(bus.err_clr),
      .iso_en(bus.iso_en[i]),
      .save(bus.save[i]),
      .restore(bus.restore[i]),
      .pwr_en(bus.pwr_en[i]),
      .dom_rst_n(bus.dom_rst_n[i]),
      .asleep(bus.asleep[i]),
      .busy(bus.busy[i]),
      .err(bus.err[i])
    );
  end
endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// tb_pwr_seq_ctrl: directed and random checks of two sequencer configurations against a timeline model
module tb_pwr_seq_ctrl;
  localparam int ND = 2;
  localparam int PGT = 16;
  localparam int AWAKE = 0, DESC = 1, WDN = 2, ASLEEP = 3, WUP = 4, ASC = 5;
  localparam logic [6:0] RST_VEC = 7'b1010000;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  pwr_seq_if #(.NUM_DOM(ND)) bus_a();
  pwr_seq_if #(.NUM_DOM(ND)) bus_b();
  pwr_seq_ctrl #(.NUM_DOM(ND)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  pwr_seq_ctrl #(.NUM_DOM(ND), .ISO_SETUP(3), .ISO_HOLD(4), .RST_SETTLE(5), .PG_TIMEOUT(PGT))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  int p_is[2] = '{1, 3};
  int p_ih[2] = '{1, 4};
  int p_rs[2] = '{2, 5};
  int checks = 0, errors = 0, cyc = 0, wbase = -1;
  int m_mode[2][ND], m_t0[2][ND];
  logic m_err[2][ND];
  logic [ND-1:0] sleep = '0, stuck_en = '0, stuck_val = '0;
  logic clr = 1'b0, a1_moved = 1'b0;
  int dly[ND];
  logic [31:0] hist[2][ND];
  logic [ND-1:0] pg_now[2];
  logic [6:0] prev[2][ND];
  logic perr[2][ND];
  logic [6:0] wav[2][ND][256];
  int t_iso_r[2][ND], t_iso_f[2][ND], t_save[2][ND], t_restore[2][ND], t_pdn[2][ND], t_pup[2][ND];
  int t_off[2][ND], t_rstn[2][ND], t_err[2][ND], n_save[2][ND], n_restore[2][ND];
  // bit order {pwr_en, iso_en, dom_rst_n, save, restore, asleep, busy}
  function automatic logic [6:0] obs(int d, int i);
    return d == 0 ? {bus_a.pwr_en[i], bus_a.iso_en[i], bus_a.dom_rst_n[i], bus_a.save[i], bus_a.restore[i], bus_a.asleep[i], bus_a.busy[i]}
                  : {bus_b.pwr_en[i], bus_b.iso_en[i], bus_b.dom_rst_n[i], bus_b.save[i], bus_b.restore[i], bus_b.asleep[i], bus_b.busy[i]};
  endfunction
  function automatic logic oerr(int d, int i);
    return d == 0 ? bus_a.err[i] : bus_b.err[i];
  endfunction
  function automatic string tag(int d, int i, string name);
    return $sformatf("%s%0d_%s", d == 0 ? "A" : "B", i, name);
  endfunction
  task automatic chk(input string name, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", name, o, e, cyc);
    end
  endtask
  // expected outputs from the coarse phase and the cycle offset into it
  function automatic logic [6:0] exp_out(int d, int i);
    int k;
    k = cyc - m_t0[d][i];
    case (m_mode[d][i])
      DESC:    return {1'b1, 1'b1, 1'b1, k == p_is[d], 1'b0, 1'b0, 1'b1};
      WDN:     return 7'b0110001;
      ASLEEP:  return 7'b0100010;
      WUP:     return 7'b1100001;
      ASC:     return {1'b1, 1'b1, k >= p_rs[d], 1'b0, k == p_rs[d], 1'b0, 1'b1};
      default: return RST_VEC;
    endcase
  endfunction
  function automatic void model_upd(int d, int i, logic s, logic pg, logic cl);
    logic set;
    set = 1'b0;
    case (m_mode[d][i])
      AWAKE:  if (s) begin m_mode[d][i] = DESC; m_t0[d][i] = cyc + 1; end
      DESC:   if (cyc == m_t0[d][i] + p_is[d]) begin m_mode[d][i] = WDN; m_t0[d][i] = cyc + 1; end
      WDN:    if (!pg) m_mode[d][i] = ASLEEP; else if (cyc + 1 - m_t0[d][i] == PGT) set = 1'b1;
      ASLEEP: if (!s) begin m_mode[d][i] = WUP; m_t0[d][i] = cyc + 1; end
      WUP:    if (pg) begin m_mode[d][i] = ASC; m_t0[d][i] = cyc + 1; end else if (cyc + 1 - m_t0[d][i] == PGT) set = 1'b1;
      default: if (cyc == m_t0[d][i] + p_rs[d] + p_ih[d]) m_mode[d][i] = AWAKE;
    endcase
    if (cl) m_err[d][i] = 1'b0;
    if (set) m_err[d][i] = 1'b1;
  endfunction
  function automatic void model_reset();
    for (int d = 0; d < 2; d++) for (int i = 0; i < ND; i++) begin
      m_mode[d][i] = AWAKE; m_t0[d][i] = 0; m_err[d][i] = 1'b0;
      hist[d][i] = '1; prev[d][i] = RST_VEC; perr[d][i] = 1'b0;
    end
  endfunction
  task automatic step();
    logic [6:0] o, po;
    logic e, pg;
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) for (int i = 0; i < ND; i++) begin
      o = obs(d, i); po = prev[d][i]; e = oerr(d, i);
      chk(tag(d, i, "out"), 32'(o), 32'(exp_out(d, i)));
      chk(tag(d, i, "err"), 32'(e), 32'(m_err[d][i]));
      chk(tag(d, i, "iso_guard"), 32'(o[5] | (o[6] & o[4])), 32'd1);
      chk(tag(d, i, "pulse_excl"), 32'(o[3] & o[2]), 32'd0);
      if (o[5] && !po[5]) t_iso_r[d][i] = cyc;
      if (!o[5] && po[5]) t_iso_f[d][i] = cyc;
      if (o[3]) begin t_save[d][i] = cyc; n_save[d][i]++; end
      if (o[2]) begin t_restore[d][i] = cyc; n_restore[d][i]++; end
      if (!o[6] && po[6]) t_pdn[d][i] = cyc;
      if (o[6] && !po[6]) t_pup[d][i] = cyc;
      if (o[4] && !po[4]) t_rstn[d][i] = cyc;
      if (o[1] && !po[1]) t_off[d][i] = cyc;
      if (e && !perr[d][i]) t_err[d][i] = cyc;
      if (d == 0 && i == 1 && (o != RST_VEC || e)) a1_moved = 1'b1;
      if (wbase >= 0 && cyc - wbase >= 0 && cyc - wbase < 256) wav[d][i][cyc - wbase] = o;
      prev[d][i] = o; perr[d][i] = e;
      hist[d][i] = {hist[d][i][30:0], o[6]};
      pg = stuck_en[i] ? stuck_val[i] : hist[d][i][dly[i]];
      pg_now[d][i] = pg;
      model_upd(d, i, sleep[i], pg, clr);
    end
    bus_a.sleep_req = sleep; bus_b.sleep_req = sleep;
    bus_a.err_clr = clr; bus_b.err_clr = clr;
    bus_a.pwr_good = pg_now[0]; bus_b.pwr_good = pg_now[1];
    clr = 1'b0;
  endtask
  initial begin
    int mism[2];
    int tmp;
    for (int i = 0; i < ND; i++) dly[i] = 3;
    model_reset();
    bus_a.sleep_req = '0; bus_b.sleep_req = '0;
    bus_a.pwr_good = '1; bus_b.pwr_good = '1;
    bus_a.err_clr = 1'b0; bus_b.err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) for (int i = 0; i < ND; i++) begin
      chk(tag(d, i, "reset_out"), 32'(obs(d, i)), 32'(RST_VEC));
      chk(tag(d, i, "reset_err"), 32'(oerr(d, i)), 32'd0);
    end
    #3 rst = 1'b1;
    // full sleep/wake cycle on domain 0
    while (cyc < 9) step();
    sleep[0] = 1'b1;
    step();
    while (cyc < 29) step();
    sleep[0] = 1'b0;
    step();
    while (cyc < 50) step();
    chk("A0_iso_rise", 32'(t_iso_r[0][0]), 32'd11);
    chk("A0_save", 32'(t_save[0][0]), 32'd12);
    chk("A0_pwr_dn", 32'(t_pdn[0][0]), 32'd13);
    chk("A0_off", 32'(t_off[0][0]), 32'd17);
    chk("A0_pwr_up", 32'(t_pup[0][0]), 32'd31);
    chk("A0_restore", 32'(t_restore[0][0]), 32'd37);
    chk("A0_rst_release", 32'(t_rstn[0][0]), 32'd37);
    chk("A0_iso_fall", 32'(t_iso_f[0][0]), 32'd39);
    chk("A1_quiet", 32'(a1_moved), 32'd0);
    chk("B0_iso_rise", 32'(t_iso_r[1][0]), 32'd11);
    chk("B0_save", 32'(t_save[1][0]), 32'd14);
    chk("B0_pwr_dn", 32'(t_pdn[1][0]), 32'd15);
    chk("B0_pwr_up", 32'(t_pup[1][0]), 32'd31);
    chk("B0_restore", 32'(t_restore[1][0]), 32'd40);
    chk("B0_iso_fall", 32'(t_iso_f[1][0]), 32'd45);
    // power-good never falls: timeout while waiting in power-down
    stuck_en[0] = 1'b1; stuck_val[0] = 1'b1; sleep[0] = 1'b1;
    step();
    for (int n = 0; n < 60 && !(bus_a.err[0] && bus_b.err[0]); n++) step();
    chk("A0_timeout_delay", 32'(t_err[0][0] - t_pdn[0][0]), 32'd16);
    chk("B0_timeout_delay", 32'(t_err[1][0] - t_pdn[1][0]), 32'd16);
    chk("A0_timeout_hold", {29'd0, bus_a.pwr_en[0], bus_a.asleep[0], bus_a.busy[0]}, 32'b001);
    repeat (5) step();
    chk("A0_timeout_still", {29'd0, bus_a.pwr_en[0], bus_a.asleep[0], bus_a.busy[0]}, 32'b001);
    clr = 1'b1;
    step();
    step();
    chk("timeout_clr", {30'd0, bus_a.err[0], bus_b.err[0]}, 32'd0);
    stuck_en[0] = 1'b0;
    for (int n = 0; n < 20 && !(bus_a.asleep[0] && bus_b.asleep[0]); n++) step();
    chk("timeout_then_off", {30'd0, bus_a.asleep[0], bus_b.asleep[0]}, 32'b11);
    sleep[0] = 1'b0;
    for (int n = 0; n < 60 && (bus_a.busy[0] || bus_b.busy[0] || bus_a.asleep[0] || bus_b.asleep[0]); n++) step();
    chk("timeout_rewake", {28'd0, bus_a.busy[0], bus_b.busy[0], bus_a.asleep[0], bus_b.asleep[0]}, 32'd0);
    // one-cycle request glitch runs a complete down/up sequence
    for (int d = 0; d < 2; d++) begin n_save[d][0] = 0; n_restore[d][0] = 0; end
    sleep[0] = 1'b1;
    step();
    sleep[0] = 1'b0;
    repeat (60) step();
    for (int d = 0; d < 2; d++) begin
      chk(tag(d, 0, "glitch_saves"), 32'(n_save[d][0]), 32'd1);
      chk(tag(d, 0, "glitch_restores"), 32'(n_restore[d][0]), 32'd1);
      chk(tag(d, 0, "glitch_final"), 32'(obs(d, 0)), 32'(RST_VEC));
    end
    // both domains, second one two cycles later
    wbase = cyc + 1;
    sleep[0] = 1'b1;
    step();
    step();
    sleep[1] = 1'b1;
    step();
    while (cyc < wbase + 59) step();
    sleep[0] = 1'b0;
    step();
    step();
    sleep[1] = 1'b0;
    step();
    while (cyc < wbase + 150) step();
    wbase = -1;
    for (int d = 0; d < 2; d++) begin
      mism[d] = 0;
      for (int k = 0; k < 148; k++) if (wav[d][1][k + 2] !== wav[d][0][k]) mism[d]++;
      chk(d == 0 ? "A_indep_offset" : "B_indep_offset", 32'(mism[d]), 32'd0);
    end
    // asynchronous reset while domain 0 waits in power-down
    sleep[0] = 1'b1;
    step();
    for (int n = 0; n < 20 && bus_a.pwr_en[0]; n++) step();
    chk("A0_in_pwr_dn", {30'd0, bus_a.pwr_en[0], bus_a.asleep[0]}, 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("A_async_pwr_en", 32'(bus_a.pwr_en), 32'(ND'('1)));
    chk("A_async_iso_en", 32'(bus_a.iso_en), 32'd0);
    for (int d = 0; d < 2; d++) for (int i = 0; i < ND; i++)
      chk(tag(d, i, "async_out"), 32'(obs(d, i)), 32'(RST_VEC));
    sleep = '0;
    model_reset();
    step();
    #3 rst = 1'b1;
    repeat (5) step();
    // random requests, power-good latencies and clears
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < ND; i++) begin
        if ($urandom_range(0, 11) == 0) sleep[i] = ~sleep[i];
        if ($urandom_range(0, 49) == 0) begin
          tmp = int'($urandom_range(1, 6));
          dly[i] = tmp == 6 ? 19 : tmp;
        end
      end
      if ($urandom_range(0, 39) == 0) clr = 1'b1;
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
